// File: rtl/gb_loader_if.sv
// -----------------------------------------------------------------------------
// gb_loader_if
// Bundles the two streams the loader sits between:
//   memory read stream : mem_valid / mem_data in, mem_ready out
//   GB write port      : write_mem_to_GB / addr_write / data_in_mem out,
//                        done_GB in
// Modports:
//   master - the loader side (drives mem_ready and the GB write port)
//   slave  - the memory + GB side (drives mem_valid, mem_data, done_GB)
// -----------------------------------------------------------------------------
interface gb_loader_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
);
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              write_mem_to_GB;
    logic [ADDR_W-1:0] addr_write;
    logic [DATA_W-1:0] data_in_mem;
    logic              done_GB;

    modport master (
        input  mem_valid,
        input  mem_data,
        input  done_GB,
        output mem_ready,
        output write_mem_to_GB,
        output addr_write,
        output data_in_mem
    );

    modport slave (
        output mem_valid,
        output mem_data,
        output done_GB,
        input  mem_ready,
        input  write_mem_to_GB,
        input  addr_write,
        input  data_in_mem
    );
endinterface

// File: rtl/gb_loader.sv
// -----------------------------------------------------------------------------
// gb_loader
// Fill engine for the global buffer. A load command (base address + word
// count) pulls 64-bit words from the memory read stream one at a time and
// writes each into the GB through its write-from-memory port, holding the
// write enable until the GB reports done_GB.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               command strobe, only looked at in IDLE
//   base_addr, len      first GB address and word count (0..512)
//   busy                high while a command is in progress
//   done                one-cycle pulse at the end of every load
//   err                 sticky watchdog flag, cleared by the next command
//   bus (master)        memory read stream + GB write port
//
// Optional feature: define GB_LOADER_TIMEOUT_EN to add a watchdog that
// abandons the load when the GB does not answer within TIMEOUT+1 WRITE
// cycles. Without it err is constant 0 and WRITE waits indefinitely.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | mem_ready high, waiting for a memory word
// S_WRITE | write_mem_to_GB high, waiting for done_GB
// S_FIN   | done pulse, back to IDLE next cycle
// -----------------------------------------------------------------------------
module gb_loader #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 11,
    parameter int DEPTH   = 512,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [9:0]        len,
    output logic              busy,
    output logic              done,
    output logic              err,
    gb_loader_if.master       bus
);

    // DEPTH is a power of two; masking keeps the address inside the GB and
    // forces the bits above it (10:9) to zero.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [9:0]        r_rem;
    logic [DATA_W-1:0] r_data;

    logic w_accept;
    logic w_take;
    logic w_commit;
    logic w_timeout;

`ifdef GB_LOADER_TIMEOUT_EN
    localparam logic [3:0] WDOG_LAST = 4'(TIMEOUT);

    logic [3:0] r_wdog;
    logic       r_err;

    // r_wdog holds the number of WRITE cycles already elapsed; the cycle in
    // which it equals TIMEOUT is the (TIMEOUT+1)-th WRITE cycle.
    assign w_timeout = (r_state == S_WRITE) && !bus.done_GB && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_WRITE) begin
                r_wdog <= r_wdog + 4'd1;
            end else begin
                r_wdog <= '0;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_take   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (len == 10'd0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.mem_valid) begin
                    w_take = 1'b1;
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.done_GB) begin
                    w_commit = 1'b1;
                    w_next   = (r_rem == 10'd1) ? S_FIN : S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= base_addr & ADDR_MASK;
                r_rem  <= len;
            end
            if (w_take) begin
                r_data <= bus.mem_data;
            end
            if (w_commit) begin
                r_rem  <= r_rem - 10'd1;
                r_addr <= (r_addr + ADDR_W'(1)) & ADDR_MASK;
            end
        end
    end

    // Write enable drops in FETCH so the GB counter restarts for every word.
    assign bus.mem_ready       = (r_state == S_FETCH);
    assign bus.write_mem_to_GB = (r_state == S_WRITE);
    assign bus.addr_write      = r_addr;
    assign bus.data_in_mem     = r_data;
    assign busy                = (r_state != S_IDLE);
    assign done                = (r_state == S_FIN);

endmodule

// File: tb/tb_gb_loader.sv
// -----------------------------------------------------------------------------
// tb_gb_loader
// Stimulus pushes expected GB writes and expected done timing into queues;
// a negedge monitor pops and compares whenever the DUT completes a GB write
// or pulses done. Memory words come from a source process with optional
// stall cycles counted while the loader is ready.
// -----------------------------------------------------------------------------
module tb_gb_loader;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [9:0]        len = '0;
    logic              busy;
    logic              done;
    logic              err;

    gb_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    gb_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // GB model: counter runs while write enable is high, done at 10.
    logic [3:0]        gb_ctr;
    logic              gb_mute = 1'b0;
    logic [DATA_W-1:0] gb_mem [512];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gb_ctr <= '0;
        else if (!bus.write_mem_to_GB) gb_ctr <= '0;
        else if (gb_ctr != 4'd10) gb_ctr <= gb_ctr + 4'd1;
    end
    assign bus.done_GB = bus.write_mem_to_GB && (gb_ctr == 4'd10) && !gb_mute;

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_pass = 0;

    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];
    int                exp_lat  [$];
    logic              exp_err  [$];
    logic [DATA_W-1:0] src_data [$];
    int                src_stall[$];
    logic              hs_pending = 1'b0;
    int                wcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory source: presents the queue head, honouring per-word stalls.
    always @(negedge clk) hs_pending = bus.mem_valid && bus.mem_ready;

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_pending) begin
                if (src_data.size() > 0) begin
                    void'(src_data.pop_front());
                    void'(src_stall.pop_front());
                end
                hs_pending = 1'b0;
            end
            if (src_data.size() > 0) begin
                if (src_stall[0] > 0) begin
                    bus.mem_valid = 1'b0;
                    bus.mem_data  = '0;
                    if (bus.mem_ready) src_stall[0] = src_stall[0] - 1;
                end else begin
                    bus.mem_valid = 1'b1;
                    bus.mem_data  = src_data[0];
                end
            end else begin
                bus.mem_valid = 1'b0;
                bus.mem_data  = '0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            wcnt = 0;
        end else begin
            if (bus.write_mem_to_GB) begin
                wcnt++;
                check("addr_hi_zero", 64'(bus.addr_write[10:9]), 64'd0);
                if (bus.done_GB) begin
                    gb_mem[bus.addr_write[8:0]] = bus.data_in_mem;
                    if (exp_addr.size() == 0) begin
                        check("unexpected_write", 64'(bus.addr_write), 64'h0BAD);
                    end else begin
                        check("wr_addr", 64'(bus.addr_write), 64'(exp_addr.pop_front()));
                        check("wr_data", bus.data_in_mem, exp_data.pop_front());
                    end
                    check("wr_len", 64'(wcnt), 64'd11);
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
            if (done) begin
                if (exp_lat.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("done_lat", 64'(cyc - start_cyc), 64'(exp_lat.pop_front()));
                    check("done_err", 64'(err), 64'(exp_err.pop_front()));
                end
                check("done_busy", 64'(busy), 64'd1);
            end
        end
    end

    task automatic push_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int stall);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        src_data.push_back(d);
        src_stall.push_back(stall);
    endtask

    task automatic issue(input logic [ADDR_W-1:0] b, input logic [9:0] n, input int lat, input logic e);
        @(posedge clk);
        #1;
        base_addr = b;
        len       = n;
        start     = 1'b1;
        exp_lat.push_back(lat);
        exp_err.push_back(e);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        check("rst_write", 64'(bus.write_mem_to_GB), 64'd0);
        check("rst_addr", 64'(bus.addr_write), 64'd0);
        check("rst_data", bus.data_in_mem, 64'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) gb_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        rst_n = 1'b1;

        // single word: done visible right after edge 12
        push_word(11'd5, 64'hDEADBEEF_01234567, 0);
        issue(11'd5, 10'd1, 12, 1'b0);
        wait_idle(200);
        check("gb5", gb_mem[5], 64'hDEADBEEF_01234567);

        // wrap; base bits 10:9 set must be discarded (0x5FE -> 510)
        push_word(11'd510, 64'd1, 0);
        push_word(11'd511, 64'd2, 0);
        push_word(11'd0,   64'd3, 0);
        push_word(11'd1,   64'd4, 0);
        issue(11'h5FE, 10'd4, 48, 1'b0);
        wait_idle(200);
        check("gb510", gb_mem[510], 64'd1);
        check("gb511", gb_mem[511], 64'd2);
        check("gb0", gb_mem[0], 64'd3);
        check("gb1", gb_mem[1], 64'd4);

        // three words, unstalled then with 5 stall cycles before word 2
        push_word(11'd20, 64'hA0, 0);
        push_word(11'd21, 64'hA1, 0);
        push_word(11'd22, 64'hA2, 0);
        issue(11'd20, 10'd3, 36, 1'b0);
        wait_idle(200);
        push_word(11'd40, 64'hB0, 0);
        push_word(11'd41, 64'hB1, 5);
        push_word(11'd42, 64'hB2, 0);
        issue(11'd40, 10'd3, 41, 1'b0);
        wait_idle(200);
        check("gb41", gb_mem[41], 64'hB1);

        // start while busy is ignored; then a zero-length load
        push_word(11'd60, 64'hC0, 0);
        push_word(11'd61, 64'hC1, 0);
        issue(11'd60, 10'd2, 24, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        base_addr = 11'd200;
        len       = 10'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(200);
        issue(11'd300, 10'd0, 0, 1'b0);
        wait_idle(20);
        check("no_extra_writes", 64'(exp_addr.size()), 64'd0);
        check("gb200_untouched", gb_mem[200], 64'd0);

        // reset during WRITE of word 2 of 4
        push_word(11'd80, 64'hD0, 0);
        push_word(11'd81, 64'hD1, 0);
        push_word(11'd82, 64'hD2, 0);
        push_word(11'd83, 64'hD3, 0);
        issue(11'd80, 10'd4, 48, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero();
        exp_addr.delete();
        exp_data.delete();
        exp_lat.delete();
        exp_err.delete();
        src_data.delete();
        src_stall.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("gb80", gb_mem[80], 64'hD0);
        check("gb81_dropped", gb_mem[81], 64'd0);
        push_word(11'd90, 64'hE0, 0);
        push_word(11'd91, 64'hE1, 0);
        issue(11'd90, 10'd2, 24, 1'b0);
        wait_idle(200);
        check("gb91", gb_mem[91], 64'hE1);

`ifdef GB_LOADER_TIMEOUT_EN
        // GB never answers: 16 WRITE cycles after edge 1 -> FIN after edge 17
        gb_mute = 1'b1;
        src_data.push_back(64'hF0);
        src_stall.push_back(0);
        src_data.push_back(64'hF1);
        src_stall.push_back(0);
        issue(11'd400, 10'd2, 17, 1'b1);
        wait_idle(200);
        check("to_err", 64'(err), 64'd1);
        check("to_write_low", 64'(bus.write_mem_to_GB), 64'd0);
        gb_mute = 1'b0;
        src_data.delete();
        src_stall.delete();
        push_word(11'd410, 64'hF5, 0);
        issue(11'd410, 10'd1, 12, 1'b0);
        check("err_cleared", 64'(err), 64'd0);
        wait_idle(200);
`else
        check("err_tied", 64'(err), 64'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("exp_wr_empty", 64'(exp_addr.size()), 64'd0);
        check("exp_done_empty", 64'(exp_lat.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
